// File: rtl/reg_scoreboard_if.sv
// Scoreboard bus: slot-advance controls from the pipeline controller in, per-register hazard codes out.
// No valid/ready pair: inputs are sampled on every rising clk, and outputs are valid every cycle.
interface reg_scoreboard_if #(
   parameter int NREG = 8
);
   localparam int AW = $clog2(NREG);

   logic                     regwrite_cur;
   logic [AW-1:0]            regwrite_adr_id;
   logic                     from_main_mem_id;
   logic                     en_idex;
   logic                     flush_idex;
   logic                     en_exmem;
   logic                     flush_exmem;
   logic                     en_memwb;
   logic                     flush_memwb;
   logic [NREG-1:0][1:0]     register_invalid;
   logic [1:0]               inflight_cnt;
   logic                     pipe_empty;

   modport slave (
      input  regwrite_cur, regwrite_adr_id, from_main_mem_id,
      input  en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
      output register_invalid, inflight_cnt, pipe_empty
   );

   modport master (
      output regwrite_cur, regwrite_adr_id, from_main_mem_id,
      output en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
      input  register_invalid, inflight_cnt, pipe_empty
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Tracks in-flight register writes in the EX/MEM/WB slots and reports per-register
// hazard codes: 0 ready, 1 stall, 2 forward from EX/MEM, 3 forward from MEM/WB.
module reg_scoreboard #(
   parameter int NREG      = 8,
   parameter bit WB_BYPASS = 1'b1
) (
   input logic             clk,
   input logic             reset,
   reg_scoreboard_if.slave bus
);
   localparam int AW = $clog2(NREG);

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] adr;
      logic          load;
   } slot_t;

   slot_t                s_ex;
   slot_t                s_mem;
   slot_t                s_wb;
   slot_t                ex_in;
   logic [NREG-1:0][1:0] codes;

   assign ex_in = {bus.regwrite_cur, bus.regwrite_adr_id, bus.from_main_mem_id};

   // Each slot mirrors its pipeline register: flush beats enable, enable beats hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_ex  <= '0;
         s_mem <= '0;
         s_wb  <= '0;
      end else begin
         if (bus.flush_idex)       s_ex <= '0;
         else if (bus.en_idex)     s_ex <= ex_in;

         if (bus.flush_exmem)      s_mem <= '0;
         else if (bus.en_exmem)    s_mem <= s_ex;

         if (bus.flush_memwb)      s_wb <= '0;
         else if (bus.en_memwb)    s_wb <= s_mem;
      end
   end

   // Oldest slot is applied first so a younger match overrides it.
   always_comb begin
      codes = '0;
      for (int r = 0; r < NREG; r++) begin
         if (s_wb.valid && s_wb.adr == AW'(r))
            codes[r] = WB_BYPASS ? 2'd0 : 2'd1;
         if (s_mem.valid && s_mem.adr == AW'(r))
            codes[r] = 2'd3;
         if (s_ex.valid && s_ex.adr == AW'(r))
            codes[r] = s_ex.load ? 2'd1 : 2'd2;
      end
   end

   assign bus.register_invalid = codes;
   assign bus.inflight_cnt     = 2'(s_ex.valid) + 2'(s_mem.valid) + 2'(s_wb.valid);
   assign bus.pipe_empty       = ~(s_ex.valid | s_mem.valid | s_wb.valid);
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: two instances (WB_BYPASS=1 and 0) share stimulus; a slot-list
// reference model feeds an expected queue that a separate monitor drains every cycle.
module tb_reg_scoreboard;
   localparam int W = 38;

   logic clk;
   logic reset;

   reg_scoreboard_if #(.NREG(8)) if1 ();
   reg_scoreboard_if #(.NREG(8)) if0 ();

   reg_scoreboard #(.NREG(8), .WB_BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   reg_scoreboard #(.NREG(8), .WB_BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           total = 0;
   int           bad   = 0;
   bit           started = 1'b0;
   bit           rst_val = 1'b1;
   event         chk_ev;

   // reference model: index 0 is the youngest in-flight write (EX), 2 the oldest (WB)
   bit       m_v[3];
   logic [2:0] m_a[3];
   bit       m_l[3];

   function automatic logic [1:0] model_code(input int r, input bit bypass);
      for (int k = 0; k < 3; k++) begin
         if (m_v[k] && m_a[k] == 3'(r)) begin
            case (k)
               0:       return m_l[k] ? 2'd1 : 2'd2;
               1:       return 2'd3;
               default: return bypass ? 2'd0 : 2'd1;
            endcase
         end
      end
      return 2'd0;
   endfunction

   function automatic logic [W-1:0] model_vec();
      logic [15:0] c1;
      logic [15:0] c0;
      int          n;
      for (int r = 0; r < 8; r++) begin
         c1[2*r +: 2] = model_code(r, 1'b1);
         c0[2*r +: 2] = model_code(r, 1'b0);
      end
      n = int'(m_v[0]) + int'(m_v[1]) + int'(m_v[2]);
      return {c1, c0, 2'(n), (n == 0), 2'(n), (n == 0)};
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         m_v[k] = 1'b0;
         m_a[k] = 3'd0;
         m_l[k] = 1'b0;
      end
   endtask

   task automatic model_clock(input bit rw, input logic [2:0] adr, input bit ld,
                              input bit eid, input bit fid, input bit eem,
                              input bit fem, input bit emw, input bit fmw);
      if (fmw) begin
         m_v[2] = 1'b0; m_a[2] = 3'd0; m_l[2] = 1'b0;
      end else if (emw) begin
         m_v[2] = m_v[1]; m_a[2] = m_a[1]; m_l[2] = m_l[1];
      end
      if (fem) begin
         m_v[1] = 1'b0; m_a[1] = 3'd0; m_l[1] = 1'b0;
      end else if (eem) begin
         m_v[1] = m_v[0]; m_a[1] = m_a[0]; m_l[1] = m_l[0];
      end
      if (fid) begin
         m_v[0] = 1'b0; m_a[0] = 3'd0; m_l[0] = 1'b0;
      end else if (eid) begin
         m_v[0] = rw; m_a[0] = adr; m_l[0] = ld;
      end
   endtask

   // driver tasks
   task automatic step(input bit rw, input logic [2:0] adr, input bit ld,
                       input bit eid, input bit fid, input bit eem,
                       input bit fem, input bit emw, input bit fmw, input string nm);
      @(negedge clk);
      reset = rst_val;
      if1.regwrite_cur = rw;  if1.regwrite_adr_id = adr; if1.from_main_mem_id = ld;
      if1.en_idex = eid;      if1.flush_idex = fid;
      if1.en_exmem = eem;     if1.flush_exmem = fem;
      if1.en_memwb = emw;     if1.flush_memwb = fmw;
      if0.regwrite_cur = rw;  if0.regwrite_adr_id = adr; if0.from_main_mem_id = ld;
      if0.en_idex = eid;      if0.flush_idex = fid;
      if0.en_exmem = eem;     if0.flush_exmem = fem;
      if0.en_memwb = emw;     if0.flush_memwb = fmw;
      if (rst_val) model_clear();
      else         model_clock(rw, adr, ld, eid, fid, eem, fem, emw, fmw);
      exp_q.push_back(model_vec());
      name_q.push_back(nm);
      started = 1'b1;
      @(posedge clk);
   endtask

   task automatic issue(input bit rw, input logic [2:0] adr, input bit ld, input string nm);
      step(rw, adr, ld, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, nm);
   endtask

   task automatic idle(input int n, input string nm);
      for (int i = 0; i < n; i++) issue(1'b0, 3'd0, 1'b0, nm);
   endtask

   task automatic async_reset_check();
      #3;
      reset   = 1'b1;
      rst_val = 1'b1;
      model_clear();
      exp_q.push_back(model_vec());
      name_q.push_back("async_reset");
      ->chk_ev;
   endtask

   // scoreboard monitor
   initial begin
      logic [W-1:0] act;
      logic [W-1:0] e;
      string        nm;
      forever begin
         @(posedge clk or chk_ev);
         #1;
         act = {if1.register_invalid, if0.register_invalid,
                if1.inflight_cnt, if1.pipe_empty, if0.inflight_cnt, if0.pipe_empty};
         if (exp_q.size() == 0) begin
            if (started) begin
               total++;
               bad++;
               $display("FAIL underflow: got=%h required=<no expectation>", act);
            end
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (act !== e) begin
               bad++;
               $display("FAIL %s: got=%h required=%h", nm, act, e);
            end
         end
      end
   end

   // stimulus
   initial begin
      reset = 1'b1;
      model_clear();
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_state");
      step(1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "reset_held");
      rst_val = 1'b0;

      issue(1'b1, 3'd3, 1'b0, "alu_chain_ex");
      idle(1, "alu_chain_mem");
      idle(1, "alu_chain_wb");
      idle(1, "alu_chain_gone");

      issue(1'b1, 3'd5, 1'b1, "load_use_ex");
      step(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "load_use_bubble");
      idle(3, "load_use_drain");

      issue(1'b1, 3'd2, 1'b0, "shadow_add");
      issue(1'b1, 3'd2, 1'b1, "shadow_ld");
      step(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "shadow_bubble");
      idle(3, "shadow_drain");

      issue(1'b1, 3'd4, 1'b0, "flush_fill");
      step(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "flush_kill");
      idle(2, "flush_drain");

      issue(1'b1, 3'd1, 1'b0, "hold_fill_a");
      issue(1'b1, 3'd6, 1'b1, "hold_fill_b");
      issue(1'b1, 3'd7, 1'b0, "hold_fill_c");
      for (int i = 0; i < 3; i++)
         step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "hold");

      async_reset_check();
      step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "reset_held2");
      rst_val = 1'b0;
      idle(1, "after_reset");

      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 1),
              ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 1),
              ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 1), "random");
      end

      #3;
      started = 1'b0;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got=%0d pending required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
